alu_arbiter: RTL and testbench

//  Shares one combinational alu instance among NUM_REQ requesters. Round-robin grant,

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_arbiter_rr_arbiter.sv | 27 ++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the alu arbiter: alu opcode encoding, arbiter FSM states and
// the helper that flags the two opcodes the alu does not implement.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic op_unsupported(input logic [ALU_OP_W-1:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping, returned as
// a one-hot grant plus its index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt_any                             = 1'b1;
                gnt_idx                             = ID_W'((int'(ptr) + i) % NUM_REQ);
                gnt[(int'(ptr) + i) % NUM_REQ]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu among NUM_REQ requesters (round-robin, IDLE->EXEC->RESP).
// Define ALU_ARB_PERF_EN to add the perf_ops / perf_busy counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in2,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_opcode,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           alu_in1,
    output logic [DATA_W-1:0]           alu_in2,
    output logic [ALU_OP_W-1:0]         alu_opcode,
    output arb_state_t                  dbg_state,
    input  logic [DATA_W-1:0]           alu_out
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_ops,
    output logic [31:0]                 perf_busy
`endif
);

    // Handshakes: a request transfers when req_valid[i] & req_ready[i] on a clock edge,
    // a response when rsp_valid & rsp_ready; valid may drop before ready with no effect.
    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     op_in1_q, op_in1_d;
    logic [DATA_W-1:0]     op_in2_q, op_in2_d;
    logic [ALU_OP_W-1:0]   op_code_q, op_code_d;
    logic [ID_W-1:0]       op_id_q, op_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  grant_en;
    logic                  accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A new op may be taken when idle, or in the same cycle the held response drains.
    assign grant_en  = !rst && ((state_q == ARB_IDLE) || (state_q == ARB_RESP && rsp_ready));
    assign accept    = grant_en && gnt_any;
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_in1_d    = op_in1_q;
        op_in2_d    = op_in2_q;
        op_code_d   = op_code_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ARB_EXEC: begin
                rsp_err_d   = op_unsupported(op_code_q);
                rsp_data_d  = op_unsupported(op_code_q) ? '0 : alu_out;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ARB_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
        if (accept) begin
            op_in1_d  = req_in1[int'(gnt_idx)*DATA_W +: DATA_W];
            op_in2_d  = req_in2[int'(gnt_idx)*DATA_W +: DATA_W];
            op_code_d = req_opcode[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W];
            op_id_d   = gnt_idx;
            rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            state_d   = ARB_EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            op_in1_q    <= '0;
            op_in2_q    <= '0;
            op_code_q   <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_in1_q    <= op_in1_d;
            op_in2_q    <= op_in2_d;
            op_code_q   <= op_code_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign alu_in1    = op_in1_q;
    assign alu_in2    = op_in2_q;
    assign alu_opcode = op_code_q;
    assign dbg_state  = state_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_ops_d  = perf_ops_q;
        perf_busy_d = perf_busy_q;
        if (rsp_valid_q && rsp_ready) perf_ops_d = perf_ops_q + 32'd1;
        if (state_q != ARB_IDLE)      perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a bench-side alu, a cycle monitor with a round-robin model and
// an expected-response queue, directed reset/fairness/backpressure/error tests, random traffic.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int EXP_W   = 1 + ID_W + DATA_W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DATA_W-1:0]   req_in1 = '0;
    logic [NUM_REQ*DATA_W-1:0]   req_in2 = '0;
    logic [NUM_REQ*ALU_OP_W-1:0] req_opcode = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b1;
    logic [DATA_W-1:0]           rsp_data;
    logic [ID_W-1:0]             rsp_id;
    logic                        rsp_err;
    logic [DATA_W-1:0]           alu_in1;
    logic [DATA_W-1:0]           alu_in2;
    logic [ALU_OP_W-1:0]         alu_opcode;
    arb_state_t                  dbg_state;
    logic [DATA_W-1:0]           alu_out;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]                 perf_ops;
    logic [31:0]                 perf_busy;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_opcode (req_opcode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .dbg_state  (dbg_state),
        .alu_out    (alu_out)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy)
`endif
    );

    function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            3'b111:  return ~a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out = alu_f(alu_in1, alu_in2, alu_opcode);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / cycle model ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               m_state = 0;   // 0 idle, 1 exec, 2 resp
    int               m_ptr   = 0;
    logic [DATA_W-1:0] m_in1  = '0;
    logic [DATA_W-1:0] m_in2  = '0;
    logic [2:0]        m_op   = '0;
    int                m_ops  = 0;
    int                m_busy = 0;

    always @(negedge clk) begin
        bit               g_en;
        bit               g_any;
        int               gi;
        logic [NUM_REQ-1:0] eg;
        logic [DATA_W-1:0] a, b;
        logic [2:0]        op;
        logic              err;

        g_en  = !rst && (m_state == 0 || (m_state == 2 && rsp_ready));
        g_any = 1'b0;
        gi    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!g_any && req_valid[(m_ptr + k) % NUM_REQ]) begin
                g_any = 1'b1;
                gi    = (m_ptr + k) % NUM_REQ;
            end
        end
        eg = '0;
        if (g_en && g_any) eg[gi] = 1'b1;

        check_eq("req_ready", 64'(req_ready), 64'(eg));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
        check_eq("alu_in1", 64'(alu_in1), 64'(m_in1));
        check_eq("alu_in2", 64'(alu_in2), 64'(m_in2));
        check_eq("alu_opcode", 64'(alu_opcode), 64'(m_op));
        if (m_state == 2) begin
            check_eq("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
                check_eq("rsp", 64'({rsp_err, rsp_id, rsp_data}), 64'(exp_q[0]));
        end

        if (rst) begin
            m_state = 0; m_ptr = 0; m_in1 = '0; m_in2 = '0; m_op = '0;
            m_ops = 0; m_busy = 0;
            exp_q.delete();
        end else begin
            if (m_state != 0) m_busy++;
            if (m_state == 1) begin
                m_state = 2;
            end else if (m_state == 2 && rsp_ready) begin
                m_ops++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_state = 0;
            end
            if (g_en && g_any) begin
                a   = req_in1[gi*DATA_W +: DATA_W];
                b   = req_in2[gi*DATA_W +: DATA_W];
                op  = req_opcode[gi*3 +: 3];
                err = (op[2:1] == 2'b01);
                exp_q.push_back({err, ID_W'(gi), err ? 32'd0 : alu_f(a, b, op)});
                m_in1 = a; m_in2 = b; m_op = op;
                m_ptr   = (gi + 1) % NUM_REQ;
                m_state = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [2:0] op);
        req_in1[i*DATA_W +: DATA_W] = a;
        req_in2[i*DATA_W +: DATA_W] = b;
        req_opcode[i*3 +: 3]        = op;
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int order[$];
        bit seen;

        // T1 reset with all requesters asserting
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 32'h10 + i, 32'h3, 3'b000);
        repeat (2) tick();
        @(negedge clk);
        check_eq("t1_req_ready", 64'(req_ready), 64'd0);
        check_eq("t1_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), 64'd0);
        check_eq("t1_alu", 64'({alu_opcode, alu_in1}), 64'd0);
        check_eq("t1_alu_in2", 64'(alu_in2), 64'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();

        // T2 single op from requester 0, response two cycles after accept
        drive_req(0, 32'h5, 32'h2, 3'b000);
        req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t2_accept", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        check_eq("t2_exec_in1", 64'(alu_in1), 64'h5);
        check_eq("t2_no_rsp_yet", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("t2_rsp", 64'({rsp_valid, rsp_err, rsp_id, rsp_data}), {29'd0, 1'b1, 1'b0, 2'd0, 32'd7});
        repeat (3) tick();

        // T3 fairness from a fresh reset
        reset_pulse(2);
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) order.push_back(k);
            tick();
        end
        check_eq("t3_grant_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            check_eq($sformatf("t3_order%0d", k), 64'(order[k]), 64'(k % 4));

        // T4 backpressure then release
        rsp_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check_eq("t4_held_valid", 64'(rsp_valid), 64'd1);
        check_eq("t4_no_grant", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        #1;
        check_eq("t4_release_grant", 64'(req_ready != 0), 64'd1);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // T5 unsupported opcode from requester 2
        drive_req(2, 32'h5, 32'h9, 3'b011);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                check_eq("t5_err_rsp", 64'({rsp_err, rsp_id, rsp_data}), {29'd0, 1'b1, 2'd2, 32'd0});
            end
            tick();
        end
        check_eq("t5_rsp_seen", 64'(seen), 64'd1);
        repeat (3) tick();

        // T6 reset while an op is executing
        drive_req(2, 32'h77, 32'h1, 3'b001);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_no_rsp", 64'(rsp_valid), 64'd0);
        drive_req(0, 32'h21, 32'h2, 3'b101);
        drive_req(1, 32'h31, 32'h4, 3'b100);
        req_valid = 4'b0011;
        #1;
        check_eq("t6_restart_req0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Random traffic with dropping valids, backpressure and bad opcodes
        for (int c = 0; c < 400; c++) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++)
                drive_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check_eq("drain_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef ALU_ARB_PERF_EN
        check_eq("perf_ops", 64'(perf_ops), 64'(m_ops));
        check_eq("perf_busy", 64'(perf_busy), 64'(m_busy));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
